hazard_forward_unit: RTL

//  Parametrised forwarding and load-use hazard unit for the in-order RISC pipeline.

---
 rtl/hazard_forward_unit_if.sv | 32 +++
 rtl/hazard_forward_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/hazard_forward_unit_if.sv
// Signal bundle between the pipeline control and the forwarding/hazard unit.
// The master side drives the ID/EX/MEM view; the slave side returns selects and stall.
interface hazard_forward_unit_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
);
  logic                      hold;
  logic                      flush;
  logic [NUM_SRC*REG_AW-1:0] if_id_rs;
  logic [NUM_SRC-1:0]        if_id_rs_used;
  logic [REG_AW-1:0]         id_ex_rd;
  logic                      id_ex_RegWrite;
  logic                      id_ex_MemRead;
  logic [REG_AW-1:0]         ex_mem_rd;
  logic                      ex_mem_RegWrite;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic                      stall;
  logic                      bubble;
  logic [15:0]               hazard_count;

  modport master (
    output hold, flush, if_id_rs, if_id_rs_used, id_ex_rd, id_ex_RegWrite,
           id_ex_MemRead, ex_mem_rd, ex_mem_RegWrite,
    input  fwd_sel, stall, bubble, hazard_count
  );

  modport slave (
    input  hold, flush, if_id_rs, if_id_rs_used, id_ex_rd, id_ex_RegWrite,
           id_ex_MemRead, ex_mem_rd, ex_mem_RegWrite,
    output fwd_sel, stall, bubble, hazard_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Operand forwarding selects and load-use stall generation for the ID stage.
// Selects are registered so they line up with the instruction once it reaches EX.
module hazard_forward_unit #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_forward_unit_if.slave  bus
);

  typedef enum logic {RUN, STALL} state_t;

  state_t               r_state, w_stateNext;
  logic [2:0]           r_cnt, w_cntNext;
  logic [2*NUM_SRC-1:0] r_fwdSel, w_fwdNext, w_fwdCalc;
  logic [15:0]          r_hazCnt, w_hazNext;
  logic [NUM_SRC-1:0]   w_mE, w_mM;
  logic                 w_lu;
  logic                 w_stall;

  // Per-source producer match; the EX producer wins over MEM because it is younger.
  always_comb begin
    w_mE      = '0;
    w_mM      = '0;
    w_fwdCalc = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_mE[k] = bus.if_id_rs_used[k] & bus.id_ex_RegWrite & (bus.id_ex_rd != '0) &
                (bus.id_ex_rd == bus.if_id_rs[k*REG_AW +: REG_AW]);
      w_mM[k] = bus.if_id_rs_used[k] & bus.ex_mem_RegWrite & (bus.ex_mem_rd != '0) &
                (bus.ex_mem_rd == bus.if_id_rs[k*REG_AW +: REG_AW]);
      if (w_mE[k])
        w_fwdCalc[2*k +: 2] = 2'b10;
      else if (w_mM[k])
        w_fwdCalc[2*k +: 2] = 2'b01;
    end
    w_lu = bus.id_ex_MemRead & (|w_mE);
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_fwdNext   = r_fwdSel;
    w_hazNext   = r_hazCnt;
    w_stall     = 1'b0;

    case (r_state)
      RUN:     w_stall = w_lu & ~bus.flush;
      STALL:   w_stall = ~bus.flush;
      default: w_stall = 1'b0;
    endcase

    if (bus.flush) begin
      w_stateNext = RUN;
      w_cntNext   = '0;
      w_fwdNext   = '0;
    end else if (!bus.hold) begin
      case (r_state)
        RUN: begin
          if (w_stall) begin
            w_fwdNext = '0;
            w_hazNext = (r_hazCnt != 16'hFFFF) ? r_hazCnt + 16'd1 : r_hazCnt;
            if (LOAD_LAT > 1) begin
              w_cntNext   = 3'(LOAD_LAT - 1);
              w_stateNext = STALL;
            end
          end else begin
            w_fwdNext = w_fwdCalc;
          end
        end
        STALL: begin
          // The RUN detect cycle is stall 1, so LOAD_LAT-1 more cycles are spent here.
          w_fwdNext = '0;
          w_cntNext = r_cnt - 3'd1;
          if (r_cnt <= 3'd1)
            w_stateNext = RUN;
        end
        default: w_stateNext = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_fwdSel <= '0;
      r_hazCnt <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_fwdSel <= w_fwdNext;
      r_hazCnt <= w_hazNext;
    end
  end

  assign bus.fwd_sel      = r_fwdSel;
  assign bus.stall        = w_stall & rst_n;
  assign bus.bubble       = w_stall & rst_n;
  assign bus.hazard_count = r_hazCnt;

endmodule
